// File: rtl/fusion_seq_ctrl.sv
// fusion_seq_ctrl
// Time-multiplexes one fusion_unit over a dot product of configurable length.
// A start request latches the job configuration, then the sequencer streams
// operand-buffer reads, one per unstalled cycle. It steers the unit's psum
// feedback so every clock accumulates one product. It waits for the last
// product to land, then captures the 19-bit result with a one-cycle done pulse.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, len, base_addr,    job request and configuration
//   s_in_cfg, s_weight_cfg,   (sampled together, only while not busy)
//   bias
//   stall                     operand buffer not ready; suppresses the read
//   rd_en, rd_addr            operand buffer read port (1-cycle latency)
//   fu_op_gate                pass buffer data to the unit (0 forces operands to 0)
//   fu_s_in, fu_s_weight      operand signedness for the unit
//   fu_psum_in                partial sum into the unit
//   fu_psum_fwd               registered partial sum out of the unit
//   busy, done, result        status, completion pulse, final psum
module fusion_seq_ctrl #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              s_in_cfg,
   input  logic              s_weight_cfg,
   input  logic [18:0]       bias,
   input  logic              stall,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              fu_op_gate,
   output logic              fu_s_in,
   output logic              fu_s_weight,
   output logic [18:0]       fu_psum_in,
   input  logic [18:0]       fu_psum_fwd,
   output logic              busy,
   output logic              done,
   output logic [18:0]       result
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_reg, state_next;
   logic [LEN_W-1:0]  len_reg;
   logic [ADDR_W-1:0] base_reg;
   logic [18:0]       bias_reg;
   logic              s_in_reg;
   logic              s_weight_reg;
   logic [LEN_W-1:0]  count_reg;
   logic              gate_reg;
   logic              first_d_reg;
   logic              last_d_reg;
   logic              last_dd_reg;
   logic [18:0]       result_reg;

   logic              start_ok;
   logic              is_last;
   logic              active;

   // A new job is only accepted when no operation is in flight.
   assign start_ok = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
   assign is_last  = (count_reg == (len_reg - LEN_W'(1)));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE, S_DONE: begin
            if (start_ok) begin
               state_next = (len == '0) ? S_DONE : S_ISSUE;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (!stall && is_last) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // last_dd marks the cycle the final product is visible on fu_psum_fwd.
            if (last_dd_reg) begin
               state_next = S_DONE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      rd_en  = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      active = 1'b0;
      case (state_reg)
         S_ISSUE: begin
            rd_en  = !stall;
            busy   = 1'b1;
            active = 1'b1;
         end
         S_DRAIN: begin
            busy   = 1'b1;
            active = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Job configuration, issue counter, pipeline flags and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_reg      <= '0;
         base_reg     <= '0;
         bias_reg     <= '0;
         s_in_reg     <= 1'b0;
         s_weight_reg <= 1'b0;
         count_reg    <= '0;
         gate_reg     <= 1'b0;
         first_d_reg  <= 1'b0;
         last_d_reg   <= 1'b0;
         last_dd_reg  <= 1'b0;
         result_reg   <= '0;
      end else begin
         // The flags travel with the read data, so they line up with fu_op_gate.
         gate_reg    <= rd_en;
         first_d_reg <= rd_en && (count_reg == '0);
         last_d_reg  <= rd_en && is_last;
         last_dd_reg <= last_d_reg;

         if (start_ok) begin
            len_reg      <= len;
            base_reg     <= base_addr;
            bias_reg     <= bias;
            s_in_reg     <= s_in_cfg;
            s_weight_reg <= s_weight_cfg;
            count_reg    <= '0;
            if (len == '0) begin
               result_reg <= bias;
            end
         end else if (rd_en) begin
            count_reg <= count_reg + LEN_W'(1);
         end

         if ((state_reg == S_DRAIN) && last_dd_reg) begin
            result_reg <= fu_psum_fwd;
         end
      end
   end

   assign rd_addr     = base_reg + ADDR_W'(count_reg);
   assign fu_op_gate  = gate_reg;
   assign fu_s_in     = s_in_reg;
   assign fu_s_weight = s_weight_reg;
   assign result      = result_reg;

   // First element seeds the accumulator with the bias. Every other cycle of
   // the job feeds the unit's own output back, so gated-off (zero operand)
   // cycles simply hold the running sum. Outside a job the port is parked at 0.
   assign fu_psum_in = (gate_reg && first_d_reg) ? bias_reg :
                       (active ? fu_psum_fwd : 19'd0);

endmodule

// File: tb/tb_fusion_seq_ctrl.sv
module tb_fusion_seq_ctrl;
   localparam int ADDR_W = 8;
   localparam int LEN_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic [ADDR_W-1:0] base_addr;
   logic              s_in_cfg;
   logic              s_weight_cfg;
   logic [18:0]       bias;
   logic              stall = 1'b0;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              fu_op_gate;
   logic              fu_s_in;
   logic              fu_s_weight;
   logic [18:0]       fu_psum_in;
   logic [18:0]       fu_psum_fwd = 19'd0;
   logic              busy;
   logic              done;
   logic [18:0]       result;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   logic [31:0] smask = 32'd0;
   int          st0 = 0;

   logic [7:0] in_mem [256];
   logic [7:0] w_mem  [256];
   logic [7:0] in_q = 8'd0;
   logic [7:0] w_q  = 8'd0;

   int exp_rd_addr [$];
   int exp_rd_cyc  [$];
   int exp_res     [$];
   int exp_res_cyc [$];

   fusion_seq_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .base_addr(base_addr),
      .s_in_cfg(s_in_cfg), .s_weight_cfg(s_weight_cfg), .bias(bias),
      .stall(stall), .rd_en(rd_en), .rd_addr(rd_addr), .fu_op_gate(fu_op_gate),
      .fu_s_in(fu_s_in), .fu_s_weight(fu_s_weight), .fu_psum_in(fu_psum_in),
      .fu_psum_fwd(fu_psum_fwd), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stall pattern: bit k of smask is the stall level in cycle k of the job started at st0.
   always @(posedge clk) begin
      #2;
      if (cyc >= st0 && (cyc - st0) < 32) stall = smask[cyc - st0];
      else stall = 1'b0;
   end

   // Operand buffer: one-cycle read latency.
   always @(posedge clk) begin
      if (rd_en) begin
         in_q <= in_mem[rd_addr];
         w_q  <= w_mem[rd_addr];
      end
   end

   function automatic logic [18:0] mac(input logic [7:0] a, input logic [7:0] b,
                                       input logic sa, input logic sb,
                                       input logic [18:0] p);
      logic signed [8:0]  ea;
      logic signed [8:0]  eb;
      logic signed [17:0] pr;
      ea = {sa & a[7], a};
      eb = {sb & b[7], b};
      pr = ea * eb;
      return p + {pr[17], pr};
   endfunction

   // Fusion unit: registered multiply-accumulate with operand gating.
   always @(posedge clk) begin
      fu_psum_fwd <= mac(fu_op_gate ? in_q : 8'd0, fu_op_gate ? w_q : 8'd0,
                         fu_s_in, fu_s_weight, fu_psum_in);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: read strobes and completions are popped against the scoreboard.
   always @(negedge clk) begin
      int ea, ec, er;
      if (rd_en === 1'b1) begin
         if (exp_rd_addr.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_rd: got read of %0h at cycle %0d, required no read", rd_addr, cyc);
         end else begin
            ea = exp_rd_addr.pop_front();
            ec = exp_rd_cyc.pop_front();
            $display("[TB] read addr=%0h cycle=%0d", rd_addr, cyc);
            check("rd_addr", 32'(rd_addr), ea);
            check("rd_cycle", cyc, ec);
         end
      end
      if (done === 1'b1) begin
         if (exp_res.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_done: got done with result %0d at cycle %0d, required no done", result, cyc);
         end else begin
            er = exp_res.pop_front();
            ec = exp_res_cyc.pop_front();
            $display("[TB] done result=%0d cycle=%0d", result, cyc);
            check("result", 32'(result), er);
            check("done_cycle", cyc, ec);
         end
      end
   end

   task automatic push_rd(input int a, input int c);
      exp_rd_addr.push_back(a);
      exp_rd_cyc.push_back(c);
   endtask

   task automatic push_res(input int r, input int c);
      exp_res.push_back(r);
      exp_res_cyc.push_back(c);
   endtask

   task automatic issue(input logic [7:0] l, input logic [7:0] b, input logic si,
                        input logic sw, input logic [18:0] bs);
      len = l; base_addr = b; s_in_cfg = si; s_weight_cfg = sw; bias = bs;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"}, 32'(rd_en), 0);
      check({tag, "_rd_addr"}, 32'(rd_addr), 0);
      check({tag, "_fu_op_gate"}, 32'(fu_op_gate), 0);
      check({tag, "_fu_s_in"}, 32'(fu_s_in), 0);
      check({tag, "_fu_s_weight"}, 32'(fu_s_weight), 0);
      check({tag, "_fu_psum_in"}, 32'(fu_psum_in), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_result"}, 32'(result), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int t, tb2;
      logic [3:0] gate_exp;
      for (int i = 0; i < 256; i++) begin
         in_mem[i] = 8'd0;
         w_mem[i]  = 8'd0;
      end
      for (int i = 0; i < 4; i++) begin
         in_mem[i]      = 8'(i + 1);      // 1,2,3,4
         w_mem[i]       = 8'(i + 5);      // 5,6,7,8
         in_mem[16 + i] = 8'h80;          // -128
         w_mem[16 + i]  = 8'h80;
      end
      in_mem[254] = 8'd3; w_mem[254] = 8'd7;
      in_mem[255] = 8'd4; w_mem[255] = 8'd8;

      rst = 1'b1; start = 1'b0; len = '0; base_addr = '0;
      s_in_cfg = 1'b0; s_weight_cfg = 1'b0; bias = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Unsigned len=4: 1*5+2*6+3*7+4*8 = 70, done in cycle 7, busy cycles 1..6
      t = cyc;
      for (int k = 0; k < 4; k++) push_rd(k, t + 1 + k);
      push_res(70, t + 7);
      check("busy_c0", 32'(busy), 0);
      issue(8'd4, 8'd0, 1'b0, 1'b0, 19'd0);
      for (int k = 1; k <= 7; k++) begin
         wait_to(t + k);
         check("busy", 32'(busy), (k <= 6) ? 1 : 0);
      end
      wait_to(t + 8);

      // Both signed: 4 * 16384 - 1 = 65535
      t = cyc;
      for (int k = 0; k < 4; k++) push_rd(16 + k, t + 1 + k);
      push_res(65535, t + 7);
      issue(8'd4, 8'd16, 1'b1, 1'b1, 19'h7FFFF);
      for (int k = 1; k <= 7; k++) begin
         wait_to(t + k);
         check("sign_outs", 32'({fu_s_in, fu_s_weight}), 3);
      end
      wait_to(t + 8);

      // Stalls in cycles 2 and 3: reads 1,4,5,6; gate low 3..4; done 9
      t = cyc;
      st0 = t;
      smask = 32'b1100;
      push_rd(0, t + 1); push_rd(1, t + 4); push_rd(2, t + 5); push_rd(3, t + 6);
      push_res(70, t + 9);
      issue(8'd4, 8'd0, 1'b0, 1'b0, 19'd0);
      gate_exp = 4'b1001;  // cycles 5,4,3,2 from MSB to LSB
      for (int k = 2; k <= 5; k++) begin
         wait_to(t + k);
         check("op_gate_stall", 32'(fu_op_gate), 32'(gate_exp[k - 2]));
      end
      wait_to(t + 10);
      smask = 32'd0;

      // Zero length: done in cycle 1 with result = bias, no read
      t = cyc;
      push_res(100, t + 1);
      issue(8'd0, 8'd0, 1'b0, 1'b0, 19'd100);
      check("len0_rd_en", 32'(rd_en), 0);
      wait_to(t + 3);

      // Address wrap: FE, FF, 00, 01 -> 3*7+4*8+1*5+2*6 = 70
      t = cyc;
      push_rd(8'hFE, t + 1); push_rd(8'hFF, t + 2); push_rd(8'h00, t + 3); push_rd(8'h01, t + 4);
      push_res(70, t + 7);
      issue(8'd4, 8'hFE, 1'b0, 1'b0, 19'd0);
      wait_to(t + 8);

      // Start while busy ignored, then back-to-back start in the done cycle
      t = cyc;
      for (int k = 0; k < 4; k++) push_rd(k, t + 1 + k);
      push_res(70, t + 7);
      issue(8'd4, 8'd0, 1'b0, 1'b0, 19'd0);
      wait_to(t + 3);
      issue(8'd7, 8'h40, 1'b0, 1'b0, 19'd5);
      wait_to(t + 7);
      check("b2b_done_seen", 32'(done), 1);
      tb2 = cyc;
      for (int k = 0; k < 4; k++) push_rd(16 + k, tb2 + 1 + k);
      push_res(65535, tb2 + 7);
      issue(8'd4, 8'd16, 1'b1, 1'b1, 19'h7FFFF);
      wait_to(tb2 + 8);

      // Reset in cycle 3 of a len=4 job: all outputs 0 in cycle 4, no done
      t = cyc;
      push_rd(0, t + 1); push_rd(1, t + 2); push_rd(2, t + 3);
      issue(8'd4, 8'd0, 1'b0, 1'b0, 19'd0);
      wait_to(t + 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("midrst");
      repeat (10) @(negedge clk);

      t = cyc;
      for (int k = 0; k < 4; k++) push_rd(k, t + 1 + k);
      push_res(70, t + 7);
      issue(8'd4, 8'd0, 1'b0, 1'b0, 19'd0);
      wait_to(t + 8);

      repeat (20) @(negedge clk);
      check("pending_reads", exp_rd_addr.size(), 0);
      check("pending_results", exp_res.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
